// File: rtl/vga_timing_gen_if.sv
// Avalon-MM status/control window and vblank interrupt of vga_timing_gen.
interface vga_timing_gen_if;
  logic        AVL_ADDR;
  logic        AVL_READ;
  logic        AVL_WRITE;
  logic        AVL_CS;
  logic [31:0] AVL_WRITEDATA;
  logic [31:0] AVL_READDATA;
  logic        IRQ;

  modport master (
    output AVL_ADDR, AVL_READ, AVL_WRITE, AVL_CS, AVL_WRITEDATA,
    input  AVL_READDATA, IRQ
  );

  modport slave (
    input  AVL_ADDR, AVL_READ, AVL_WRITE, AVL_CS, AVL_WRITEDATA,
    output AVL_READDATA, IRQ
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel enable, scan counters, delayed sync/blank and
// a vblank-interrupt status/control register window.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic             CLK_50,
  input  logic             RESET,
  vga_timing_gen_if.slave  avl,
  output logic [9:0]       DrawX,
  output logic [9:0]       DrawY,
  output logic             PIX_EN,
  output logic             VGA_CLK,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic             VGA_SYNC_N
);
  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef enum logic {
    REG_STATUS  = 1'b0,
    REG_CONTROL = 1'b1
  } reg_addr_e;

  logic        d;
  logic [9:0]  hc;
  logic [9:0]  vc;
  logic        hs_raw;
  logic        vs_raw;
  logic        blank_raw;
  logic        vblank_evt;
  logic [15:0] frame_cnt;
  logic        irq_pend;
  logic        irq_en;
  logic [31:0] rdata;
  logic [31:0] status_word;
  logic        rd_strobe;
  logic        wr_strobe;
  reg_addr_e   reg_addr;

  always_ff @(posedge CLK_50) begin
    if (!RESET) d <= 1'b0;
    else        d <= ~d;
  end

  always_ff @(posedge CLK_50) begin
    if (!RESET) begin
      hc <= '0;
      vc <= '0;
    end else if (d) begin
      if (hc == 10'(H_TOTAL - 1)) begin
        hc <= '0;
        if (vc == 10'(V_TOTAL - 1)) vc <= '0;
        else                        vc <= vc + 10'd1;
      end else begin
        hc <= hc + 10'd1;
      end
    end
  end

  always_comb begin
    hs_raw     = !((hc >= 10'(H_SYNC_START)) && (hc < 10'(H_SYNC_END)));
    vs_raw     = !((vc >= 10'(V_SYNC_START)) && (vc < 10'(V_SYNC_END)));
    blank_raw  = (hc < 10'(H_VISIBLE)) && (vc < 10'(V_VISIBLE));
    vblank_evt = d && (hc == 10'(H_TOTAL - 1)) && (vc == 10'(V_VISIBLE - 1));
  end

  // Sync/blank lag the raw raster so they align with the tile table's pixel latency.
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign VGA_HS      = hs_raw;
    assign VGA_VS      = vs_raw;
    assign VGA_BLANK_N = blank_raw;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] hs_pipe;
    logic [PIPE_DELAY-1:0] vs_pipe;
    logic [PIPE_DELAY-1:0] blank_pipe;

    always_ff @(posedge CLK_50) begin
      if (!RESET) begin
        hs_pipe    <= '1;
        vs_pipe    <= '1;
        blank_pipe <= '0;
      end else if (d) begin
        hs_pipe    <= PIPE_DELAY'({hs_pipe, hs_raw});
        vs_pipe    <= PIPE_DELAY'({vs_pipe, vs_raw});
        blank_pipe <= PIPE_DELAY'({blank_pipe, blank_raw});
      end
    end

    assign VGA_HS      = hs_pipe[PIPE_DELAY-1];
    assign VGA_VS      = vs_pipe[PIPE_DELAY-1];
    assign VGA_BLANK_N = blank_pipe[PIPE_DELAY-1];
  end

  always_comb begin
    reg_addr    = reg_addr_e'(avl.AVL_ADDR);
    rd_strobe   = avl.AVL_CS && avl.AVL_READ;
    wr_strobe   = avl.AVL_CS && avl.AVL_WRITE;
    status_word = {frame_cnt, 14'd0, (vc >= 10'(V_VISIBLE)), irq_pend};
  end

  // The vblank set is applied after the W1C clear so a same-cycle collision keeps the interrupt pending.
  always_ff @(posedge CLK_50) begin
    if (!RESET) begin
      frame_cnt <= '0;
      irq_pend  <= 1'b0;
      irq_en    <= 1'b0;
      rdata     <= '0;
    end else begin
      if (wr_strobe) begin
        if (reg_addr == REG_CONTROL)    irq_en   <= avl.AVL_WRITEDATA[0];
        else if (avl.AVL_WRITEDATA[0])  irq_pend <= 1'b0;
      end
      if (vblank_evt) begin
        frame_cnt <= frame_cnt + 16'd1;
        irq_pend  <= 1'b1;
      end
      if (rd_strobe) begin
        if (reg_addr == REG_STATUS) rdata <= status_word;
        else                        rdata <= {31'd0, irq_en};
      end
    end
  end

  assign avl.AVL_READDATA = rdata;
  assign avl.IRQ          = irq_pend & irq_en;
  assign DrawX            = hc;
  assign DrawY            = vc;
  assign PIX_EN           = d;
  assign VGA_CLK          = d;
  assign VGA_SYNC_N       = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a shrunken raster, against a
// cycle-count based reference model.
module tb_vga_timing_gen;
  localparam int HV   = 16;
  localparam int HF   = 4;
  localparam int HS_W = 6;
  localparam int HB   = 4;
  localparam int VV   = 8;
  localparam int VF   = 2;
  localparam int VS_W = 2;
  localparam int VB   = 3;
  localparam int D    = 2;
  localparam int HT   = HV + HF + HS_W + HB;
  localparam int VT   = VV + VF + VS_W + VB;
  localparam int FRAME_CYC = 2 * HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] draw_x, draw_y;
  logic       pix_en, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  vga_timing_gen_if avl();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS_W), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS_W), .V_BP(VB),
    .PIPE_DELAY(D)
  ) dut (
    .CLK_50(clk), .RESET(rst_n), .avl(avl),
    .DrawX(draw_x), .DrawY(draw_y), .PIX_EN(pix_en), .VGA_CLK(vga_clk),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_N(vga_blank_n), .VGA_SYNC_N(vga_sync_n)
  );

  always #5 clk = ~clk;

  int          n_run = 0;
  int          n_fail = 0;
  // Reference model: edges since reset release plus the software-visible registers.
  int          m_n = 0;
  logic [15:0] m_fc = '0;
  bit          m_pend = 0;
  bit          m_en = 0;
  logic [31:0] m_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pix_h(int pix); return pix % HT; endfunction
  function automatic int pix_v(int pix); return (pix / HT) % VT; endfunction
  function automatic bit hs_at(int pix);
    return !(pix_h(pix) >= HV + HF && pix_h(pix) < HV + HF + HS_W);
  endfunction
  function automatic bit vs_at(int pix);
    return !(pix_v(pix) >= VV + VF && pix_v(pix) < VV + VF + VS_W);
  endfunction
  function automatic bit blank_at(int pix);
    return pix_h(pix) < HV && pix_v(pix) < VV;
  endfunction
  function automatic bit next_is_vblank();
    return (m_n % 2 == 1) && pix_h(m_n / 2) == HT - 1 && pix_v(m_n / 2) == VV - 1;
  endfunction

  task automatic compare_all();
    int p, q;
    bit eh, ev, eb;
    p = m_n / 2;
    q = p - D;
    if (q < 0) begin
      eh = 1; ev = 1; eb = 0;
    end else begin
      eh = hs_at(q); ev = vs_at(q); eb = blank_at(q);
    end
    check("pix_en",   32'(pix_en),           32'(m_n % 2));
    check("vga_clk",  32'(vga_clk),          32'(m_n % 2));
    check("draw_x",   32'(draw_x),           32'(pix_h(p)));
    check("draw_y",   32'(draw_y),           32'(pix_v(p)));
    check("vga_hs",   32'(vga_hs),           32'(eh));
    check("vga_vs",   32'(vga_vs),           32'(ev));
    check("blank_n",  32'(vga_blank_n),      32'(eb));
    check("sync_n",   32'(vga_sync_n),       32'(0));
    check("irq",      32'(avl.IRQ),          32'(m_pend & m_en));
    check("readdata", avl.AVL_READDATA,      m_rd);
  endtask

  task automatic step(input bit r, input bit cs, input bit rd, input bit wr,
                      input bit a, input logic [31:0] wd);
    int hc, vc;
    bit evt;
    rst_n = r; avl.AVL_CS = cs; avl.AVL_READ = rd; avl.AVL_WRITE = wr;
    avl.AVL_ADDR = a; avl.AVL_WRITEDATA = wd;
    @(posedge clk);
    hc = pix_h(m_n / 2);
    vc = pix_v(m_n / 2);
    if (!r) begin
      m_n = 0; m_fc = '0; m_pend = 0; m_en = 0; m_rd = '0;
    end else begin
      evt = (m_n % 2 == 1) && hc == HT - 1 && vc == VV - 1;
      if (cs && rd) m_rd = a ? {31'd0, m_en} : {m_fc, 14'd0, (vc >= VV), m_pend};
      if (cs && wr) begin
        if (a)          m_en = wd[0];
        else if (wd[0]) m_pend = 0;
      end
      if (evt) begin
        m_fc = m_fc + 16'd1;
        m_pend = 1;
      end
      m_n++;
    end
    #1;
    compare_all();
  endtask

  task automatic idle(); step(1, 0, 0, 0, 0, 32'd0); endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int run_hs, run_bl, run_vs, waited;
    bit prev_hs, r, cs, rw, a;
    avl.AVL_CS = 0; avl.AVL_READ = 0; avl.AVL_WRITE = 0;
    avl.AVL_ADDR = 0; avl.AVL_WRITEDATA = '0;

    // Reset state
    repeat (3) step(0, 0, 0, 0, 0, 32'd0);
    check("rst_draw_x", 32'(draw_x), 32'd0);
    check("rst_hs",     32'(vga_hs), 32'd1);
    check("rst_blank",  32'(vga_blank_n), 32'd0);
    check("rst_rdata",  avl.AVL_READDATA, 32'd0);
    idle();
    check("first_pix_en", 32'(pix_en), 32'd1);

    // IRQ enable, first vblank, W1C
    step(1, 1, 0, 1, 1, 32'd1);
    for (waited = 0; waited < FRAME_CYC + 10 && m_fc != 16'd1; waited++) idle();
    check("vblank_reached", 32'(m_fc), 32'd1);
    check("irq_at_vblank", 32'(avl.IRQ), 32'd1);
    step(1, 1, 1, 0, 0, 32'd0);
    check("status_pending", avl.AVL_READDATA, 32'h0001_0003);
    step(1, 1, 0, 1, 0, 32'd1);
    check("irq_after_w1c", 32'(avl.IRQ), 32'd0);
    step(1, 1, 1, 0, 0, 32'd0);
    check("status_cleared", avl.AVL_READDATA, 32'h0001_0002);

    // W1C on the exact vblank edge: set wins
    for (waited = 0; waited < FRAME_CYC + 10 && !next_is_vblank(); waited++) idle();
    check("vblank_edge_found", 32'(next_is_vblank()), 32'd1);
    step(1, 1, 0, 1, 0, 32'd1);
    check("irq_race", 32'(avl.IRQ), 32'd1);
    step(1, 1, 1, 0, 0, 32'd0);
    check("status_race", avl.AVL_READDATA, 32'h0002_0003);

    // Mid-frame reset at (10,5)
    for (waited = 0; waited < FRAME_CYC + 10 && !(pix_h(m_n / 2) == 10 && pix_v(m_n / 2) == 5); waited++)
      idle();
    step(0, 0, 0, 0, 0, 32'd0);
    check("mid_rst_xy", {22'd0, draw_x}, 32'd0);
    check("mid_rst_y",  {22'd0, draw_y}, 32'd0);
    check("mid_rst_pix", 32'(pix_en), 32'd0);
    check("mid_rst_vs", 32'(vga_vs), 32'd1);
    check("mid_rst_irq", 32'(avl.IRQ), 32'd0);
    check("mid_rst_rdata", avl.AVL_READDATA, 32'd0);
    step(1, 1, 1, 0, 1, 32'd0);
    check("ctrl_after_rst", avl.AVL_READDATA, 32'd0);

    // Sync and blank pulse widths over two frames
    step(0, 0, 0, 0, 0, 32'd0);
    run_hs = 0; run_bl = 0; run_vs = 0; prev_hs = 1;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      idle();
      if (prev_hs && !vga_hs) check("hs_start_x", 32'(draw_x), 32'(HV + HF + D));
      prev_hs = vga_hs;
      if (!vga_hs) run_hs++;
      else if (run_hs > 0) begin check("hs_low_len", 32'(run_hs), 32'(2 * HS_W)); run_hs = 0; end
      if (vga_blank_n) run_bl++;
      else if (run_bl > 0) begin check("blank_len", 32'(run_bl), 32'(2 * HV)); run_bl = 0; end
      if (!vga_vs) run_vs++;
      else if (run_vs > 0) begin check("vs_low_len", 32'(run_vs), 32'(2 * VS_W * HT)); run_vs = 0; end
    end

    // Randomized bus traffic and occasional resets
    for (int i = 0; i < 20000; i++) begin
      r = ($urandom_range(3999) != 0);
      if ($urandom_range(7) == 0) begin
        cs = ($urandom_range(9) != 0);
        rw = $urandom_range(1);
        a  = $urandom_range(1);
        step(r, cs, rw, !rw, a, $urandom);
      end else begin
        step(r, 0, 0, 0, 0, 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
